// File: rtl/soc_mgmt_pkg.sv
// Shared types for the soc_mgmt clock bring-up logic.
// Holds the PLL divider field widths and the sequencer state encoding.
package soc_mgmt_pkg;

    localparam int PLL_M_W = 10;
    localparam int PLL_P_W = 6;
    localparam int PLL_S_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TO_REF    = 3'd1,
        ST_PLL_RST   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_TO_PLL    = 3'd4,
        ST_RUN       = 3'd5,
        ST_ERROR     = 3'd6
    } pll_seq_state_e;

endpackage

// File: rtl/soc_mgmt_pll_seq_timer.sv
// Loadable saturating down-counter; expired is high once the count hits zero.
// A phase that loads N stays for N+1 cycles before expired is seen.
module soc_mgmt_pll_seq_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/soc_mgmt_pll_seq.sv
// PLL bring-up sequencer: park on REF, reset/program PLL, wait for stable
// lock, switch the glitch-free mux to the PLL and supervise lock in RUN.
module soc_mgmt_pll_seq
    import soc_mgmt_pkg::*;
#(
    parameter int ResetCycles      = 16,
    parameter int LockTimeout      = 4096,
    parameter int LockStableCycles = 8,
    parameter int MuxTimeout       = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [PLL_M_W-1:0] i_div_main,
    input  logic [PLL_P_W-1:0] i_div_pre,
    input  logic [PLL_S_W-1:0] i_div_scalar,
    output logic               o_pll_resetb,
    output logic [PLL_M_W-1:0] o_pll_div_main,
    output logic [PLL_P_W-1:0] o_pll_div_pre,
    output logic [PLL_S_W-1:0] o_pll_div_scalar,
    input  logic               i_pll_lock,
    output logic               o_mux_select,
    output logic               o_mux_enable,
    input  logic [1:0]         i_mux_active,
    output logic [2:0]         o_state,
    output logic               o_busy,
    output logic               o_running,
    output logic               o_err_timeout,
    output logic               o_err_lock_lost
);

    localparam int TMax1 = (LockTimeout > MuxTimeout) ? LockTimeout : MuxTimeout;
    localparam int TMax  = (TMax1 > ResetCycles) ? TMax1 : ResetCycles;
    localparam int TW    = $clog2(TMax + 1);
    localparam int SW    = $clog2(LockStableCycles + 1);

    pll_seq_state_e state;
    pll_seq_state_e state_nxt;
    logic           resetb_nxt;
    logic           accept;
    logic           set_timeout;
    logic           set_lost;
    logic           tmr_load;
    logic [TW-1:0]  tmr_value;
    logic           tmr_expired;
    logic [SW-1:0]  stable;
    logic [SW-1:0]  stable_inc;
    logic           lock_ok;

    soc_mgmt_pll_seq_timer #(.W(TW)) u_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    always_comb begin
        if (!i_pll_lock) begin
            stable_inc = '0;
        end else if (stable == SW'(LockStableCycles)) begin
            stable_inc = stable;
        end else begin
            stable_inc = stable + SW'(1);
        end
        lock_ok = (stable_inc == SW'(LockStableCycles));
    end

    always_comb begin
        state_nxt   = state;
        resetb_nxt  = o_pll_resetb;
        set_timeout = 1'b0;
        set_lost    = 1'b0;
        accept      = i_start && !i_stop &&
                      (state inside {ST_IDLE, ST_RUN, ST_ERROR});
        if (i_stop && state != ST_IDLE) begin
            state_nxt  = ST_IDLE;
            resetb_nxt = 1'b0;
        end else if (accept) begin
            state_nxt = ST_TO_REF;
        end else begin
            case (state)
                ST_TO_REF: begin
                    if (i_mux_active == 2'b01) begin
                        state_nxt  = ST_PLL_RST;
                        resetb_nxt = 1'b0;
                    end else if (tmr_expired) begin
                        state_nxt   = ST_ERROR;
                        set_timeout = 1'b1;
                    end
                end
                ST_PLL_RST: begin
                    if (tmr_expired) begin
                        state_nxt  = ST_WAIT_LOCK;
                        resetb_nxt = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_nxt = ST_TO_PLL;
                    end else if (tmr_expired) begin
                        state_nxt   = ST_ERROR;
                        set_timeout = 1'b1;
                    end
                end
                ST_TO_PLL: begin
                    if (!i_pll_lock) begin
                        state_nxt = ST_ERROR;
                        set_lost  = 1'b1;
                    end else if (i_mux_active == 2'b10) begin
                        state_nxt = ST_RUN;
                    end else if (tmr_expired) begin
                        state_nxt   = ST_ERROR;
                        set_timeout = 1'b1;
                    end
                end
                ST_RUN: begin
                    // resetb stays high so the lost lock can be inspected
                    if (!i_pll_lock) begin
                        state_nxt = ST_ERROR;
                        set_lost  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tmr_load = (state_nxt != state);
        case (state_nxt)
            ST_PLL_RST:   tmr_value = TW'(ResetCycles - 1);
            ST_WAIT_LOCK: tmr_value = TW'(LockTimeout - 1);
            default:      tmr_value = TW'(MuxTimeout - 1);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            o_pll_resetb     <= 1'b0;
            o_pll_div_main   <= '0;
            o_pll_div_pre    <= '0;
            o_pll_div_scalar <= '0;
            o_err_timeout    <= 1'b0;
            o_err_lock_lost  <= 1'b0;
            stable           <= '0;
        end else begin
            state        <= state_nxt;
            o_pll_resetb <= resetb_nxt;
            if (accept) begin
                o_pll_div_main   <= i_div_main;
                o_pll_div_pre    <= i_div_pre;
                o_pll_div_scalar <= i_div_scalar;
                o_err_timeout    <= 1'b0;
                o_err_lock_lost  <= 1'b0;
            end else begin
                if (set_timeout) o_err_timeout <= 1'b1;
                if (set_lost) o_err_lock_lost <= 1'b1;
            end
            if (state == ST_WAIT_LOCK && state_nxt == ST_WAIT_LOCK) begin
                stable <= stable_inc;
            end else begin
                stable <= '0;
            end
        end
    end

    assign o_state      = state;
    assign o_mux_select = (state inside {ST_TO_PLL, ST_RUN});
    assign o_mux_enable = 1'b1;
    assign o_busy       = (state inside {ST_TO_REF, ST_PLL_RST,
                                         ST_WAIT_LOCK, ST_TO_PLL});
    assign o_running    = (state == ST_RUN);

endmodule
